// File: rtl/spi_adc_responder.sv
// ADC088S102-style SPI slave: streams the selected 8-bit channel value back to the
// polling master and takes the next channel address from the control bits on mosi.
module spi_adc_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        sck_i,
  input  logic        cs_n_i,
  input  logic        mosi_i,
  input  logic [63:0] chan_data_i,
  output logic        miso_o,
  output logic        miso_oe_o,
  output logic [2:0]  cur_chan_o,
  output logic        frame_done_o,
  output logic        frame_error_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;

  logic [0:0]  state_q, state_d;
  logic [3:0]  rise_cnt_q, rise_cnt_d;
  logic [3:0]  fall_cnt_q, fall_cnt_d;
  logic [15:0] tx_q, tx_d;
  logic [7:0]  hold_q, hold_d;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  cur_chan_q, cur_chan_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;
  logic [7:0] sel_byte;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign sel_byte = chan_data_i[{cur_chan_q, 3'b000} +: 8];

  always_comb begin
    state_d    = state_q;
    rise_cnt_d = rise_cnt_q;
    fall_cnt_d = fall_cnt_q;
    tx_d       = tx_q;
    hold_d     = hold_q;
    pend_d     = pend_q;
    cur_chan_d = cur_chan_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d    = ST_FRAME;
          rise_cnt_d = 4'd0;
          fall_cnt_d = 4'd0;
          pend_d     = 3'd0;
          hold_d     = sel_byte;
          tx_d       = {4'b0000, sel_byte, 4'b0000};
        end
      end
      default: begin
        if (cs_rise) begin
          // A partial frame leaves the channel selection untouched.
          state_d = ST_IDLE;
          tx_d    = 16'd0;
          pend_d  = 3'd0;
          err_d   = (rise_cnt_q != 4'd0);
        end else if (!cs_s) begin
          if (sck_rise) begin
            rise_cnt_d = rise_cnt_q + 4'd1;
            if (rise_cnt_q >= 4'd2 && rise_cnt_q <= 4'd4)
              pend_d[3'd4 - rise_cnt_q[2:0]] = mosi_s;
            if (rise_cnt_q == 4'd15) begin
              done_d     = 1'b1;
              cur_chan_d = pend_q;
            end
          end
          if (sck_fall) begin
            fall_cnt_d = fall_cnt_q + 4'd1;
            if (fall_cnt_q == 4'd15) begin
              // Continuous mode: cur_chan was already updated on the 16th rise.
              hold_d = sel_byte;
              tx_d   = {4'b0000, sel_byte, 4'b0000};
            end else begin
              tx_d = {tx_q[14:0], 1'b0};
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      rise_cnt_q  <= 4'd0;
      fall_cnt_q  <= 4'd0;
      tx_q        <= 16'd0;
      hold_q      <= 8'd0;
      pend_q      <= 3'd0;
      cur_chan_q  <= 3'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      rise_cnt_q  <= rise_cnt_d;
      fall_cnt_q  <= fall_cnt_d;
      tx_q        <= tx_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      cur_chan_q  <= cur_chan_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign miso_oe_o     = (state_q == ST_FRAME);
  assign miso_o        = miso_oe_o & tx_q[15];
  assign cur_chan_o    = cur_chan_q;
  assign frame_done_o  = done_q;
  assign frame_error_o = err_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: table of single frames plus hand-written
// continuous, abort, mid-frame data change and mid-frame reset sequences.
module tb_spi_adc_responder;
  logic        clk = 1'b0;
  logic        reset, sck, cs_n, mosi;
  logic [63:0] chan_data;
  logic        miso, miso_oe, frame_done, frame_error;
  logic [2:0]  cur_chan;

  int checks = 0;
  int failures = 0;
  int n_done = 0;
  int n_err = 0;

  spi_adc_responder #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .reset_i(reset), .sck_i(sck), .cs_n_i(cs_n), .mosi_i(mosi),
    .chan_data_i(chan_data), .miso_o(miso), .miso_oe_o(miso_oe),
    .cur_chan_o(cur_chan), .frame_done_o(frame_done), .frame_error_o(frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done)  n_done++;
    if (frame_error) n_err++;
  end

  typedef struct {
    logic [2:0] add;
    logic [7:0] exp_byte;
    logic [2:0] exp_chan;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // nbits SCK periods; miso sampled just before each rising edge, MSB first.
  task automatic xfer(input logic [2:0] add, input int nbits, input int chg_at,
                      input logic [63:0] chg_val, output logic [15:0] word);
    logic [15:0] ctl;
    ctl  = {2'b00, add, 11'b0};
    word = '0;
    for (int k = 0; k < nbits; k++) begin
      mosi = ctl[15-k];
      if (k == chg_at) chan_data = chg_val;
      wait_clk(8);
      word = {word[14:0], miso};
      sck = 1'b1;
      wait_clk(8);
      sck = 1'b0;
    end
    wait_clk(8);
  endtask

  task automatic frame(input string nm, input logic [2:0] add, input logic [7:0] exp_byte,
                       input logic [2:0] exp_chan, input int chg_at, input logic [63:0] chg_val);
    logic [15:0] w;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    cs_n = 1'b0;
    wait_clk(8);
    xfer(add, 16, chg_at, chg_val, w);
    cs_n = 1'b1;
    wait_clk(8);
    chk({nm, "_word"}, {16'd0, w}, {16'd0, 4'b0, exp_byte, 4'b0});
    chk({nm, "_chan"}, {29'd0, cur_chan}, {29'd0, exp_chan});
    chk({nm, "_done"}, n_done - d0, 1);
    chk({nm, "_err"},  n_err - e0, 0);
    chk({nm, "_oe"},   {30'd0, miso_oe, miso}, 0);
  endtask

  vec_t tbl[7];
  logic [63:0] base;

  initial begin
    logic [15:0] w;
    int d0, e0, n;

    base = {8'h81, 8'h66, 8'hFF, 8'h00, 8'h3C, 8'h5A, 8'h22, 8'hA5};
    tbl[0] = '{3'd3, 8'hA5, 3'd3};
    tbl[1] = '{3'd7, 8'h3C, 3'd7};
    tbl[2] = '{3'd5, 8'h81, 3'd5};
    tbl[3] = '{3'd4, 8'hFF, 3'd4};
    tbl[4] = '{3'd2, 8'h00, 3'd2};
    tbl[5] = '{3'd6, 8'h5A, 3'd6};
    tbl[6] = '{3'd0, 8'h66, 3'd0};

    reset = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; chan_data = base;
    wait_clk(4);
    chk("rst_state", {25'd0, cur_chan, miso, miso_oe, frame_done, frame_error}, 0);
    reset = 1'b0;
    wait_clk(4);
    chk("idle_oe", {30'd0, miso_oe, miso}, 0);

    for (int i = 0; i < 7; i++)
      frame($sformatf("vec%0d", i), tbl[i].add, tbl[i].exp_byte, tbl[i].exp_chan, -1, base);

    // Continuous mode: 32 SCKs under one chip select.
    chan_data = {base[63:16], 8'h22, 8'h11};
    d0 = n_done; e0 = n_err;
    cs_n = 1'b0;
    wait_clk(8);
    chk("cont_oe", {31'd0, miso_oe}, 1);
    xfer(3'd1, 16, -1, chan_data, w);
    chk("cont_w1", {16'd0, w}, 32'h0110);
    xfer(3'd2, 16, -1, chan_data, w);
    chk("cont_w2", {16'd0, w}, 32'h0220);
    cs_n = 1'b1;
    wait_clk(8);
    chk("cont_done", n_done - d0, 2);
    chk("cont_err", n_err - e0, 0);
    chk("cont_chan", {29'd0, cur_chan}, 2);

    // Abort after 6 SCKs; address bits 5 are seen but must be discarded.
    d0 = n_done; e0 = n_err;
    cs_n = 1'b0;
    wait_clk(8);
    xfer(3'd5, 6, -1, chan_data, w);
    cs_n = 1'b1;
    wait_clk(8);
    chk("abort_err", n_err - e0, 1);
    chk("abort_done", n_done - d0, 0);
    chk("abort_chan", {29'd0, cur_chan}, 2);
    chk("abort_oe", {30'd0, miso_oe, miso}, 0);
    frame("post_abort", 3'd0, 8'h5A, 3'd0, -1, chan_data);

    // Channel data changes mid-frame: frame in progress keeps the old byte.
    chan_data = {base[63:8], 8'h0F};
    frame("chg_a", 3'd0, 8'h0F, 3'd0, 6, {base[63:8], 8'hF0});
    frame("chg_b", 3'd0, 8'hF0, 3'd0, -1, chan_data);

    // Reset at SCK 9 with cs_n held low.
    e0 = n_err;
    cs_n = 1'b0;
    wait_clk(8);
    xfer(3'd3, 9, -1, chan_data, w);
    reset = 1'b1;
    wait_clk(2);
    chk("mrst_out", {25'd0, cur_chan, miso, miso_oe, frame_done, frame_error}, 0);
    reset = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (miso_oe) break;
    end
    chk("mrst_lat", n, 3);
    chk("mrst_err", n_err - e0, 0);
    d0 = n_done;
    xfer(3'd1, 16, -1, chan_data, w);
    cs_n = 1'b1;
    wait_clk(8);
    chk("mrst_word", {16'd0, w}, 32'h0F00);
    chk("mrst_done", n_done - d0, 1);
    chk("mrst_chan", {29'd0, cur_chan}, 1);
    chk("mrst_err2", n_err - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
